// File: rtl/tempsens_uart_report_if.sv
// -----------------------------------------------------------------------------
// tempsens_uart_report_if
// Bundles the result input strobe and the UART/status outputs of the
// temperature-sensor UART reporter.
//   master : drives i_res / i_res_valid, observes o_tx and status flags
//   slave  : the reporter itself
// Signals:
//   i_res        [N_RES-1:0] result code (unsigned)
//   i_res_valid              single-cycle strobe, i_res is new
//   o_tx                     UART TX line, 8N1, LSB first, idle high
//   o_busy                   record transmission in progress
//   o_pending                a captured result waits in the pending buffer
//   o_overrun                one-cycle pulse, pending buffer overwritten
// -----------------------------------------------------------------------------
interface tempsens_uart_report_if #(
  parameter int N_RES = 7
);
  logic [N_RES-1:0] i_res;
  logic             i_res_valid;
  logic             o_tx;
  logic             o_busy;
  logic             o_pending;
  logic             o_overrun;

  modport master (
    output i_res, i_res_valid,
    input  o_tx, o_busy, o_pending, o_overrun
  );

  modport slave (
    input  i_res, i_res_valid,
    output o_tx, o_busy, o_pending, o_overrun
  );
endinterface

// File: rtl/tempsens_uart_report.sv
// -----------------------------------------------------------------------------
// tempsens_uart_report
// Captures each valid temperature-sensor result and sends it on a UART TX
// line as a 5-character ASCII record: three decimal digits, CR, LF.
// A one-deep pending buffer holds a result that arrives mid-record; a second
// arrival overwrites it and pulses o_overrun.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    tempsens_uart_report_if.slave (i_res, i_res_valid, o_tx, o_busy,
//          o_pending, o_overrun)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle high, waiting for a result strobe
// SEND   | shifting out a record; char 0..4, bit 0..9, baud 0..CPB-1
// -----------------------------------------------------------------------------
module tempsens_uart_report #(
  parameter int N_RES       = 7,
  parameter int CLK_PER_BIT = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  tempsens_uart_report_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam int              BW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_PER_BIT - 1);

  logic [0:0]    r_state;
  logic [8:0]    r_tx_val;
  logic [8:0]    r_pend_val;
  logic          r_pend_full;
  logic          r_overrun;
  logic [2:0]    r_char_idx;
  logic [3:0]    r_bit_idx;
  logic [BW-1:0] r_baud_cnt;

  logic [N_RES-1:0] w_res;
  logic [8:0]       w_res_ext;
  logic [7:0]       w_char;
  logic             w_bit_end;
  logic             w_rec_end;
  logic             w_tx;

  assign w_res     = bus.i_res;
  assign w_res_ext = 9'(w_res);

  assign w_bit_end = (r_state == S_SEND) && (r_baud_cnt == BAUD_LAST);
  assign w_rec_end = w_bit_end && (r_bit_idx == 4'd9) && (r_char_idx == 3'd4);

  // Digits are derived from r_tx_val, which is stable for the whole record.
  always_comb begin
    w_char = 8'h0A;
    case (r_char_idx)
      3'd0:    w_char = 8'h30 + 8'(r_tx_val / 9'd100);
      3'd1:    w_char = 8'h30 + 8'((r_tx_val / 9'd10) % 9'd10);
      3'd2:    w_char = 8'h30 + 8'(r_tx_val % 9'd10);
      3'd3:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  // bit 0 = start, 1..8 = data LSB first, 9 = stop
  always_comb begin
    w_tx = 1'b1;
    if (r_state == S_SEND) begin
      if (r_bit_idx == 4'd0)
        w_tx = 1'b0;
      else if (r_bit_idx != 4'd9)
        w_tx = w_char[3'(r_bit_idx - 4'd1)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tx_val    <= '0;
      r_pend_val  <= '0;
      r_pend_full <= 1'b0;
      r_overrun   <= 1'b0;
      r_char_idx  <= '0;
      r_bit_idx   <= '0;
      r_baud_cnt  <= '0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_char_idx <= '0;
          r_bit_idx  <= '0;
          r_baud_cnt <= '0;
          if (bus.i_res_valid) begin
            r_tx_val <= w_res_ext;
            r_state  <= S_SEND;
          end
        end
        default: begin
          if (w_rec_end) begin
            r_char_idx <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            // Chain straight into the next record when anything is queued;
            // a strobe on this edge never counts as an overrun.
            if (r_pend_full) begin
              r_tx_val <= r_pend_val;
              if (bus.i_res_valid)
                r_pend_val <= w_res_ext;
              else
                r_pend_full <= 1'b0;
            end else if (bus.i_res_valid) begin
              r_tx_val <= w_res_ext;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            if (w_bit_end) begin
              r_baud_cnt <= '0;
              if (r_bit_idx == 4'd9) begin
                r_bit_idx  <= '0;
                r_char_idx <= r_char_idx + 3'd1;
              end else begin
                r_bit_idx <= r_bit_idx + 4'd1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (bus.i_res_valid) begin
              r_pend_val  <= w_res_ext;
              r_pend_full <= 1'b1;
              if (r_pend_full)
                r_overrun <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_tx      = w_tx;
  assign bus.o_busy    = (r_state == S_SEND);
  assign bus.o_pending = r_pend_full;
  assign bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_tempsens_uart_report.sv
// -----------------------------------------------------------------------------
// tb_tempsens_uart_report
// Two reporters (CLK_PER_BIT = 4 and 1) share a clock and are exercised one
// after the other. A reference model tracks, per instance, whether a record is
// on the line, its value and the elapsed cycle; the expected TX level is
// computed from the 8N1 frame layout and decimal digits of that value.
// -----------------------------------------------------------------------------
module tb_tempsens_uart_report;

  localparam int N_RES = 7;
  localparam int CPB0  = 4;
  localparam int CPB1  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N_RES-1:0] res_d  [2];
  logic             vld_d  [2];
  logic             rstn_d [2];

  tempsens_uart_report_if #(.N_RES(N_RES)) bus0 ();
  tempsens_uart_report_if #(.N_RES(N_RES)) bus1 ();

  assign bus0.i_res       = res_d[0];
  assign bus0.i_res_valid = vld_d[0];
  assign bus1.i_res       = res_d[1];
  assign bus1.i_res_valid = vld_d[1];

  tempsens_uart_report #(.N_RES(N_RES), .CLK_PER_BIT(CPB0)) u_dut0 (
    .clk   (clk),
    .rst_n (rstn_d[0]),
    .bus   (bus0)
  );

  tempsens_uart_report #(.N_RES(N_RES), .CLK_PER_BIT(CPB1)) u_dut1 (
    .clk   (clk),
    .rst_n (rstn_d[1]),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model state
  bit m_busy [2];
  int m_val  [2];
  int m_el   [2];
  bit m_pf   [2];
  int m_pend [2];
  bit m_ovr  [2];
  int ovr_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  function automatic int ch_code(input int v, input int c);
    case (c)
      0:       return 48 + v / 100;
      1:       return 48 + (v / 10) % 10;
      2:       return 48 + v % 10;
      3:       return 13;
      default: return 10;
    endcase
  endfunction

  function automatic logic exp_tx(input int d);
    int pos, c, b;
    if (!m_busy[d]) return 1'b1;
    pos = m_el[d] / cpb(d);
    c   = pos / 10;
    b   = pos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return logic'((ch_code(m_val[d], c) >> (b - 1)) & 1);
  endfunction

  task automatic model_step(input int d, input logic rst_n, input logic v, input int val);
    int rec_len;
    rec_len = 50 * cpb(d);
    if (!rst_n) begin
      m_busy[d] = 1'b0;
      m_el[d]   = 0;
      m_pf[d]   = 1'b0;
      m_ovr[d]  = 1'b0;
    end else begin
      m_ovr[d] = 1'b0;
      if (!m_busy[d]) begin
        if (v) begin
          m_busy[d] = 1'b1;
          m_val[d]  = val;
          m_el[d]   = 0;
        end
      end else if (m_el[d] == rec_len - 1) begin
        m_el[d] = 0;
        if (m_pf[d]) begin
          m_val[d] = m_pend[d];
          if (v) m_pend[d] = val;
          else   m_pf[d]   = 1'b0;
        end else if (v) begin
          m_val[d] = val;
        end else begin
          m_busy[d] = 1'b0;
        end
      end else begin
        m_el[d]++;
        if (v) begin
          if (m_pf[d]) m_ovr[d] = 1'b1;
          m_pend[d] = val;
          m_pf[d]   = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rstn_d[0], vld_d[0], int'(res_d[0]));
    model_step(1, rstn_d[1], vld_d[1], int'(res_d[1]));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx0",      32'(bus0.o_tx),      32'(exp_tx(0)));
      chk("busy0",    32'(bus0.o_busy),    32'(m_busy[0]));
      chk("pending0", 32'(bus0.o_pending), 32'(m_pf[0]));
      chk("overrun0", 32'(bus0.o_overrun), 32'(m_ovr[0]));
      chk("tx1",      32'(bus1.o_tx),      32'(exp_tx(1)));
      chk("busy1",    32'(bus1.o_busy),    32'(m_busy[1]));
      chk("pending1", 32'(bus1.o_pending), 32'(m_pf[1]));
      chk("overrun1", 32'(bus1.o_overrun), 32'(m_ovr[1]));
      if (bus0.o_overrun === 1'b1) ovr_cnt[0]++;
      if (bus1.o_overrun === 1'b1) ovr_cnt[1]++;
    end
  end

  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.o_busy : bus1.o_busy;
  endfunction

  function automatic logic [2:0] flags_of(input int d);
    if (d == 0) return {bus0.o_tx, bus0.o_busy, bus0.o_pending};
    return {bus1.o_tx, bus1.o_busy, bus1.o_pending};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int d, input int v);
    res_d[d] = N_RES'(v);
    vld_d[d] = 1'b1;
    @(negedge clk);
    vld_d[d] = 1'b0;
  endtask

  task automatic wait_el(input int d, input int target);
    int n;
    n = 0;
    while (!(m_busy[d] && m_el[d] == target) && n < 200 * cpb(d) + 20) begin
      cyc(1);
      n++;
    end
    if (!(m_busy[d] && m_el[d] == target))
      chk("wait_el_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (m_busy[d] && n < 400 * cpb(d) + 20) begin
      cyc(1);
      n++;
    end
    if (m_busy[d])
      chk("wait_idle_timeout", 32'(n), 32'(0));
    cyc(2);
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    while (busy_of(d) === 1'b1 && n < 1000 * cpb(d)) begin
      n++;
      cyc(1);
    end
  endtask

  task automatic suite(input int d);
    int rec, n, o0;
    rec = 50 * cpb(d);

    rstn_d[d] = 1'b0;
    cyc(2);
    chk("reset_flags", 32'(flags_of(d)), 32'(3'b100));
    rstn_d[d] = 1'b1;
    cyc(2);

    // single record, busy length
    strobe(d, 42);
    count_busy(d, n);
    chk("busy_len", 32'(n), 32'(rec));
    cyc(3);

    strobe(d, 127);
    wait_idle(d);
    cyc(5);
    strobe(d, 0);
    wait_idle(d);

    // pending result chains back-to-back
    strobe(d, 10);
    wait_el(d, 29);
    strobe(d, 20);
    count_busy(d, n);
    chk("busy_back2back", 32'(n), 32'(2 * rec - 30));
    cyc(2);

    // overrun: 20 lost, 30 sent
    o0 = ovr_cnt[d];
    strobe(d, 10);
    wait_el(d, 5);
    strobe(d, 20);
    wait_el(d, 15);
    strobe(d, 30);
    wait_idle(d);
    chk("overrun_pulses", 32'(ovr_cnt[d] - o0), 32'(1));

    // strobe on the end edge, pending empty
    strobe(d, 55);
    wait_el(d, rec - 1);
    strobe(d, 66);
    wait_idle(d);

    // strobe on the end edge, pending full
    o0 = ovr_cnt[d];
    strobe(d, 10);
    wait_el(d, 5);
    strobe(d, 20);
    wait_el(d, rec - 1);
    strobe(d, 30);
    wait_idle(d);
    chk("end_edge_no_overrun", 32'(ovr_cnt[d] - o0), 32'(0));

    // reset during char1 data bits with pending full
    strobe(d, 100);
    wait_el(d, 3 * cpb(d));
    strobe(d, 99);
    wait_el(d, 13 * cpb(d));
    rstn_d[d] = 1'b0;
    cyc(1);
    rstn_d[d] = 1'b1;
    chk("midrec_reset_flags", 32'(flags_of(d)), 32'(3'b100));
    cyc(3);
    strobe(d, 7);
    wait_idle(d);

    // randomized results and spacing
    for (int i = 0; i < 25; i++) begin
      strobe(d, int'($urandom_range(0, 127)));
      if ($urandom_range(0, 3) == 0)
        cyc(int'($urandom_range(0, 2 * rec)));
      else
        cyc(int'($urandom_range(0, rec / 3)));
    end
    wait_idle(d);
    wait_idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      res_d[d]   = '0;
      vld_d[d]   = 1'b0;
      rstn_d[d]  = 1'b0;
      ovr_cnt[d] = 0;
    end
    cyc(2);
    chk_en = 1'b1;
    rstn_d[0] = 1'b1;
    rstn_d[1] = 1'b1;
    cyc(1);
    suite(0);
    suite(1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tempsens_uart_report.md
Name: tempsens_uart_report

Overview:
Downstream consumer of the temperature-sensor result (calibrated or raw 7-bit code). Each valid result is captured and sent out on a single UART TX line as a fixed 5-character ASCII record: three decimal digits, CR, LF. This gives a logging path alongside the 7-segment display. It provides a one-deep pending buffer so a result arriving mid-transmission is not lost, plus overrun signalling.

Parameters:
N_RES, 7, width of result input; legal range 1..9 (max value 511 fits three digits)
CLK_PER_BIT, 8, clk cycles per UART bit (≈1250 baud at clk=10 kHz); legal range ≥1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
i_res  input  N_RES  result code to report (unsigned binary)
i_res_valid  input  1  single-cycle strobe: i_res is a new result this cycle
o_tx  output  1  UART TX, 8N1, LSB first, idle high
o_busy  output  1  record transmission in progress
o_pending  output  1  a captured result waits in the pending buffer
o_overrun  output  1  one-cycle pulse: pending buffer overwritten, older result lost

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low. rst_n low at a posedge → next cycle: o_tx=1, o_busy=0, o_pending=0, o_overrun=0, bit/char/baud counters 0, state IDLE. Applies mid-record too: frame aborted, no stop bit completed, pending value discarded.
- States: IDLE, SEND. In SEND, sub-counters: char index 0..4, bit index 0..9 (0=start, 1..8=data LSB first, 9=stop), baud counter 0..CLK_PER_BIT-1.
- Capture: IDLE and i_res_valid=1 at edge N → tx register := i_res; SEND from N+1; o_busy=1 and o_tx=0 (start bit of char 0) from cycle N+1.
- Each bit held exactly CLK_PER_BIT cycles. Characters back-to-back (stop bit immediately followed by next start bit, no gap). Record = 50 bits = 50*CLK_PER_BIT cycles.
- Characters: char0 = 0x30+hundreds, char1 = 0x30+tens, char2 = 0x30+ones of tx register (leading zeros always sent, e.g. 5 → "005"), char3 = 0x0D, char4 = 0x0A. Digits derived from the tx register held constant for the whole record; i_res changes during SEND have no effect.
- End of record: edge where the last stop-bit cycle of char4 completes. If o_pending=0 → IDLE, o_busy=0, o_tx=1 next cycle. If o_pending=1 → pending value moves into tx register, o_pending=0, o_busy stays 1, next start bit begins next cycle (no idle cycle between records).
- i_res_valid while SEND (not at end edge): pending empty → pending := i_res, o_pending=1 next cycle. Pending full → pending overwritten with newest i_res, o_overrun=1 for exactly one cycle.
- i_res_valid at end edge: pending empty → value captured directly into tx register, next record starts with it. Pending full → pending moves to tx register and new value becomes pending; no overrun.
- i_res_valid in IDLE while o_pending=1 cannot occur (pending is only non-empty in SEND); no further handling required.
- Width rule: i_res zero-extended to 9 bits before digit split; hundreds ∈ 0..5.

Test Plan:
- CLK_PER_BIT=4, reset, i_res=42 strobed at edge N → o_tx from N+1: bytes 0x30,0x34,0x32,0x0D,0x0A, each 10 bits × 4 cycles, LSB first; o_busy high exactly 200 cycles; o_tx=1 afterwards.
- i_res=127 then, after idle, i_res=0 → records "127\r\n" and "000\r\n"; no overrun.
- Strobe 10, then 20 at cycle 30 of the record → o_pending=1; second record "020\r\n" starts the cycle after the first ends, with no idle high cycle; o_busy continuous for 400 cycles.
- Strobe 10, then 20 and 30 during the same record → o_overrun one-cycle pulse on the 30 strobe; second record is "030"; 20 is never sent.
- Strobe at exact end edge with pending empty → next record starts immediately with new value; with pending full → pending sent next, new value pending, o_overrun stays 0.
- rst_n low for one edge mid char1 data bits with pending full → next cycle o_tx=1, o_busy=0, o_pending=0; later strobe 7 → clean "007\r\n"; CLK_PER_BIT=1 run of same checks passes.
